// File: rtl/sobel_window_buffer.sv
// Raster-order 3x3 window buffer that feeds the Sobel edge detector. It issues one start pulse
// per valid window and stalls the pixel source until the detector's data-ready handshake ends.
module sobel_window_buffer #(
    parameter int unsigned IMG_WIDTH  = 16,
    parameter int unsigned IMG_HEIGHT = 16
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       i_clear,
    input  logic       i_pixel_valid,
    input  logic [7:0] i_pixel_data,
    output logic       o_pixel_ready,
    output logic       o_gradient_start,
    output logic [7:0] P0,
    output logic [7:0] P1,
    output logic [7:0] P2,
    output logic [7:0] P3,
    output logic [7:0] P4,
    output logic [7:0] P5,
    output logic [7:0] P6,
    output logic [7:0] P7,
    output logic [7:0] P8,
    input  logic       i_gradient_data_ready,
    output logic       o_frame_done
);

    localparam int unsigned CW = $clog2(IMG_WIDTH);
    localparam int unsigned RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] ColLast = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] RowLast = RW'(IMG_HEIGHT - 1);

    typedef enum logic [1:0] {StAccept, StStart, StWaitDone, StWaitLow} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [7:0]    win_q [9];
    logic [7:0]    win_d [9];
    logic [7:0]    line_a_q [IMG_WIDTH];
    logic [7:0]    line_b_q [IMG_WIDTH];
    logic          last_q, last_d;
    logic          frame_done_q, frame_done_d;
    logic          accept;
    logic          win_valid;
    logic          at_col_end;
    logic          at_row_end;

    always_comb begin
        accept     = i_pixel_valid && (state_q == StAccept) && !i_clear;
        at_col_end = (col_q == ColLast);
        at_row_end = (row_q == RowLast);
        win_valid  = (row_q >= RW'(2)) && (col_q >= CW'(2));

        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        win_d        = win_q;
        last_d       = last_q;
        frame_done_d = 1'b0;

        if (i_clear) begin
            state_d = StAccept;
            col_d   = '0;
            row_d   = '0;
            last_d  = 1'b0;
            for (int i = 0; i < 9; i++) begin
                win_d[i] = '0;
            end
        end else begin
            if (accept) begin
                win_d[0] = win_q[1];
                win_d[1] = win_q[2];
                win_d[2] = line_b_q[col_q];
                win_d[3] = win_q[4];
                win_d[4] = win_q[5];
                win_d[5] = line_a_q[col_q];
                win_d[6] = win_q[7];
                win_d[7] = win_q[8];
                win_d[8] = i_pixel_data;
                if (at_col_end) begin
                    col_d = '0;
                    row_d = at_row_end ? '0 : row_q + RW'(1);
                end else begin
                    col_d = col_q + CW'(1);
                end
                if (win_valid) begin
                    state_d = StStart;
                    last_d  = at_col_end && at_row_end;
                end
            end
            unique case (state_q)
                StAccept: ;
                StStart: state_d = StWaitDone;
                StWaitDone: begin
                    if (i_gradient_data_ready) begin
                        state_d = StWaitLow;
                    end
                end
                StWaitLow: begin
                    if (!i_gradient_data_ready) begin
                        state_d      = StAccept;
                        frame_done_d = last_q;
                        last_d       = 1'b0;
                    end
                end
                default: state_d = StAccept;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= StAccept;
            col_q        <= '0;
            row_q        <= '0;
            last_q       <= 1'b0;
            frame_done_q <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            last_q       <= last_d;
            frame_done_q <= frame_done_d;
            win_q        <= win_d;
        end
    end

    // Line buffer contents are don't-care after reset; row/col gating hides stale data.
    always_ff @(posedge clk) begin
        if (accept) begin
            line_b_q[col_q] <= line_a_q[col_q];
            line_a_q[col_q] <= i_pixel_data;
        end
    end

    assign o_pixel_ready    = (state_q == StAccept);
    assign o_gradient_start = (state_q == StStart);
    assign o_frame_done     = frame_done_q;
    assign P0 = win_q[0];
    assign P1 = win_q[1];
    assign P2 = win_q[2];
    assign P3 = win_q[3];
    assign P4 = win_q[4];
    assign P5 = win_q[5];
    assign P6 = win_q[6];
    assign P7 = win_q[7];
    assign P8 = win_q[8];

endmodule
